// File: rtl/seg_scan_pkg.sv
// seg_scan_pkg: shared types, frame field layout and key indexing for the segment scan master
package seg_scan_pkg;
    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DWELL, S_LATCH} state_t;
    localparam int FRAME_BITS = 8;
    localparam int COL_MSB = 7;
    localparam int SCR_MSB = 5;
    localparam int DIG_MSB = 3;
    function automatic logic [3:0] key_idx(input logic [1:0] row, input logic [1:0] col);
        return {row, col};
    endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: per-key consecutive-scan debounce of a raw 16-bit key vector
module key_debounce #(
    parameter int DEB_SCANS = 3
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic [15:0] raw_i,
    input  logic        scan_done_i,
    output logic [15:0] keys_o,
    output logic        key_change_o
);
    logic [15:0][2:0] cnt_q, cnt_d;
    logic [15:0]      keys_q, keys_d;
    logic             chg_q, chg_d;

    // A key flips only after DEB_SCANS consecutive completed scans disagree with it
    always_comb begin
        cnt_d  = cnt_q;
        keys_d = keys_q;
        for (int i = 0; i < 16; i++) begin
            if (scan_done_i) begin
                if (raw_i[i] != keys_q[i]) begin
                    if (cnt_q[i] == 3'(DEB_SCANS - 1)) begin
                        keys_d[i] = ~keys_q[i];
                        cnt_d[i]  = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 3'd1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
        end
        chg_d = keys_d != keys_q;
    end

    // Counters, key bitmap and the change pulse, cleared asynchronously
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            cnt_q  <= '0;
            keys_q <= '0;
            chg_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            keys_q <= keys_d;
            chg_q  <= chg_d;
        end
    end

    assign keys_o       = keys_q;
    assign key_change_o = chg_q;
endmodule

// File: rtl/seg_scan_master.sv
// seg_scan_master: SPI frame generator and keypad scanner driving the segment-decode slave
module seg_scan_master
    import seg_scan_pkg::*;
#(
    parameter int SCK_DIV   = 4,
    parameter int DWELL     = 1000,
    parameter int GAP       = 2,
    parameter int DEB_SCANS = 3
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        run,
    input  logic [15:0] digits_in,
    input  logic        miso,
    output logic        sck,
    output logic        mosi,
    output logic        en,
    output logic [15:0] keys,
    output logic        key_change
);
    localparam logic [31:0] SCK_LAST   = 32'(SCK_DIV - 1);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam logic [31:0] GAP_LAST   = 32'(GAP - 1);
    localparam logic [2:0]  BIT_LAST   = 3'(FRAME_BITS - 1);

    state_t                  state_q, state_d;
    logic [31:0]             cnt_q, cnt_d;
    logic [2:0]              bit_q, bit_d;
    logic                    sck_q, sck_d;
    logic [FRAME_BITS-1:0]   sr_q, sr_d;
    logic [3:0]              t_q, t_d;
    logic                    prev_valid_q, prev_valid_d;
    logic [15:0]             raw_q, raw_d;
    logic                    scan_done;
    logic [3:0]              t_prev;

    function automatic logic [FRAME_BITS-1:0] frame_of(input logic [3:0] t, input logic [15:0] d);
        logic [FRAME_BITS-1:0] f;
        f[COL_MSB -: 2] = t[1:0];
        f[SCR_MSB -: 2] = t[3:2];
        f[DIG_MSB -: 4] = d[{t[3:2], 2'b00} +: 4];
        return f;
    endfunction

    // The slave reports the key of the previously latched step
    assign t_prev = t_q - 4'd1;

    // Frame sequencing: shift 8 bits, dwell for display, then gap low so the slave latches
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        sck_d        = sck_q;
        sr_d         = sr_q;
        t_d          = t_q;
        prev_valid_d = prev_valid_q;
        raw_d        = raw_q;
        scan_done    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_SHIFT;
                    cnt_d   = '0;
                    bit_d   = '0;
                    sck_d   = 1'b0;
                    sr_d    = frame_of(t_q, digits_in);
                end
            end
            S_SHIFT: begin
                if (cnt_q == SCK_LAST) begin
                    cnt_d = '0;
                    sck_d = ~sck_q;
                    if (sck_q) begin
                        if (bit_q == BIT_LAST) begin
                            state_d = S_DWELL;
                        end else begin
                            bit_d = bit_q + 3'd1;
                            sr_d  = {sr_q[FRAME_BITS-2:0], 1'b0};
                        end
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_DWELL: begin
                if (cnt_q == DWELL_LAST) begin
                    cnt_d        = '0;
                    state_d      = S_LATCH;
                    prev_valid_d = 1'b1;
                    if (prev_valid_q) begin
                        raw_d[key_idx(t_prev[3:2], t_prev[1:0])] = ~miso;
                        scan_done = t_prev == 4'd15;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            default: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d = '0;
                    t_d   = t_q + 4'd1;
                    bit_d = '0;
                    if (run) begin
                        state_d = S_SHIFT;
                        sr_d    = frame_of(t_q + 4'd1, digits_in);
                    end else begin
                        state_d      = S_IDLE;
                        prev_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
        endcase
    end

    // Scan state registers, cleared asynchronously so outputs drop without a clock
    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            sck_q        <= 1'b0;
            sr_q         <= '0;
            t_q          <= '0;
            prev_valid_q <= 1'b0;
            raw_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            sck_q        <= sck_d;
            sr_q         <= sr_d;
            t_q          <= t_d;
            prev_valid_q <= prev_valid_d;
            raw_q        <= raw_d;
        end
    end

    assign sck  = sck_q;
    assign mosi = sr_q[FRAME_BITS-1];
    assign en   = (state_q == S_SHIFT) || (state_q == S_DWELL);

    key_debounce #(.DEB_SCANS(DEB_SCANS)) u_deb (
        .clk          (clk),
        .RESET        (RESET),
        .raw_i        (raw_d),
        .scan_done_i  (scan_done),
        .keys_o       (keys),
        .key_change_o (key_change)
    );
endmodule

// File: tb/tb_seg_scan_master.sv
// tb_seg_scan_master: slave model plus frame/debounce reference for seg_scan_master
module tb_seg_scan_master;
    localparam int SCK_DIV = 2;
    localparam int DWELL   = 10;
    localparam int GAP     = 2;
    localparam int DEB     = 3;

    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        run = 1'b0;
    logic [15:0] digits_in = 16'h4321;
    logic        miso;
    logic        sck, mosi, en, key_change;
    logic [15:0] keys;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] phys = '0;
    logic [7:0]  sh = '0;
    logic [7:0]  latched = '0;
    int          step = 0;
    bit          fresh = 1'b1;
    bit          mon_on = 1'b0;
    int          cyc = 0;
    int          t_rise = 0;
    int          t_fall = 0;
    int          rises = 0;
    int          pulses = 0;
    int          k;
    logic [15:0] dig_snap = '0;
    logic [15:0] raw_m = '0;
    logic [15:0] exp_keys = '0;
    logic        exp_chg = 1'b0;
    int          cnt_m [16];
    logic [7:0]  log_b [16];

    always #5 clk = ~clk;

    // Slave pulls miso low while the byte it last latched addresses a pressed key
    assign miso = ~phys[{latched[5:4], latched[7:6]}];

    seg_scan_master #(.SCK_DIV(SCK_DIV), .DWELL(DWELL), .GAP(GAP), .DEB_SCANS(DEB)) dut (
        .clk        (clk),
        .RESET      (RESET),
        .run        (run),
        .digits_in  (digits_in),
        .miso       (miso),
        .sck        (sck),
        .mosi       (mosi),
        .en         (en),
        .keys       (keys),
        .key_change (key_change)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] frame_ref(input int s, input logic [15:0] d);
        int col, scr, v;
        col = s % 4;
        scr = (s / 4) % 4;
        v = (col << 6) | (scr << 4) | ((int'(d) >> (4 * scr)) & 15);
        return v[7:0];
    endfunction

    task automatic wait_frames(input int n);
        repeat (n) @(negedge en);
        #3;
    endtask

    always @(posedge clk) begin
        cyc++;
        if (key_change) pulses++;
    end

    always @(posedge sck) if (mon_on) begin
        sh = {sh[6:0], mosi};
        rises++;
    end

    always @(posedge en) if (mon_on) begin
        if (!fresh) chk("gap_clks", cyc - t_fall, GAP);
        t_rise   = cyc;
        rises    = 0;
        dig_snap = digits_in;
    end

    // Frame end: check timing and content, then apply the scan/debounce rules to the reference
    always @(negedge en) begin
        if (mon_on) begin
            chk("en_high_clks", cyc - t_rise, 16 * SCK_DIV + DWELL);
            chk("sck_rises", rises, 8);
            chk("frame_byte", sh, frame_ref(step, dig_snap));
            exp_chg = 1'b0;
            if (!fresh) begin
                k = {latched[5:4], latched[7:6]};
                raw_m[k] = phys[k];
                if (k == 15) begin
                    for (int i = 0; i < 16; i++) begin
                        if (raw_m[i] != exp_keys[i]) begin
                            cnt_m[i]++;
                            if (cnt_m[i] == DEB) begin
                                exp_keys[i] = ~exp_keys[i];
                                cnt_m[i] = 0;
                                exp_chg = 1'b1;
                            end
                        end else begin
                            cnt_m[i] = 0;
                        end
                    end
                end
            end
            fresh   = 1'b0;
            latched = sh;
            if (step < 16) log_b[step] = sh;
            step++;
            #1;
            chk("keys", keys, exp_keys);
            chk("key_change", key_change, exp_chg);
        end
        t_fall = cyc;
    end

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int saved_step;
        for (int i = 0; i < 16; i++) cnt_m[i] = 0;
        #2 RESET = 1'b0;
        #1;
        chk("rst_sck", sck, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_en", en, 0);
        chk("rst_keys", keys, 0);
        chk("rst_key_change", key_change, 0);
        #20;
        @(negedge clk) RESET = 1'b1;
        repeat (5) @(negedge clk);
        chk("idle_en", en, 0);
        chk("idle_sck", sck, 0);
        mon_on = 1'b1;
        fresh  = 1'b1;
        run    = 1'b1;
        wait_frames(17);
        chk("step0_byte", log_b[0], 8'h01);
        chk("step5_byte", log_b[5], 8'h52);
        chk("step15_byte", log_b[15], 8'hF4);
        pulses = 0;
        phys[6] = 1'b1;
        wait_frames(65);
        chk("press_key6", keys[6], 1);
        chk("press_pulses", pulses, 1);
        pulses = 0;
        phys[6] = 1'b0;
        wait_frames(65);
        chk("release_key6", keys[6], 0);
        chk("release_pulses", pulses, 1);
        pulses = 0;
        phys[6] = 1'b1;
        wait_frames(32);
        phys[6] = 1'b0;
        wait_frames(65);
        chk("bounce_key6", keys[6], 0);
        chk("bounce_pulses", pulses, 0);
        repeat (6) begin
            phys = 16'($urandom);
            if ($urandom_range(0, 1) == 1) digits_in = 16'($urandom);
            wait_frames($urandom_range(16, 64));
        end
        phys = 16'h00F0;
        wait_frames(65);
        chk("held_keys", keys, 16'h00F0);
        mon_on = 1'b0;
        @(posedge en);
        repeat (3) @(posedge clk);
        @(negedge clk) RESET = 1'b0;
        #1;
        chk("midrst_sck", sck, 0);
        chk("midrst_mosi", mosi, 0);
        chk("midrst_en", en, 0);
        chk("midrst_keys", keys, 0);
        chk("midrst_key_change", key_change, 0);
        step     = 0;
        exp_keys = '0;
        raw_m    = '0;
        phys     = '0;
        for (int i = 0; i < 16; i++) cnt_m[i] = 0;
        fresh  = 1'b1;
        mon_on = 1'b1;
        @(negedge clk) RESET = 1'b1;
        wait_frames(2);
        @(posedge en);
        repeat (5) @(posedge sck);
        @(negedge clk) run = 1'b0;
        @(negedge en);
        #3;
        saved_step = step;
        repeat (20) @(negedge clk);
        chk("run_off_en", en, 0);
        chk("run_off_sck", sck, 0);
        chk("run_off_frames", step, saved_step);
        fresh = 1'b1;
        run   = 1'b1;
        wait_frames(2);
        chk("resume_frames", step, saved_step + 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/seg_scan_master.md
# seg_scan_master

Upstream SPI frame generator and keypad scanner for the segment-decode slave. Continuously cycles 16 scan steps, shifting one 8-bit frame per step (`{col[1:0], scr[1:0], digit[3:0]}`, MSB first) over SCK/MOSI/EN. It samples the slave's active-low MISO key return and publishes a debounced 16-key bitmap. It replaces the external microcontroller that previously drove the slave.

## Interface
Parameters:
- `SCK_DIV`, 4, clk cycles per SCK half-period (≥1)
- `DWELL`, 1000, clk cycles EN stays high after the 8th bit (display visible)
- `GAP`, 2, clk cycles EN low between frames (slave latch), ≥1
- `DEB_SCANS`, 3, consecutive agreeing full scans before a key bit changes (1..7)

Ports:
- `clk`  in  1  system clock
- `RESET`  in  1  reset, asynchronous, active-low
- `run`  in  1  scan enable; level
- `digits_in`  in  16  four hex digits; nibble n shown on screen n
- `miso`  in  1  slave key return, low = pressed
- `sck`  out  1  SPI clock to slave, idle low
- `mosi`  out  1  SPI data, valid across rising sck
- `en`  out  1  frame enable; slave latches on falling edge
- `keys`  out  16  debounced key bitmap, bit = 4*row+col
- `key_change`  out  1  one-clk pulse when any `keys` bit changes

## Operation
- States: IDLE, SHIFT, DWELL, LATCH.
- IDLE: en=0, sck=0. Exits to SHIFT when `run`=1.
- Step counter t (4 bits): scr=t[3:2], col=t[1:0]. Frame byte = {col, scr, digits_in[4*scr+3:4*scr]}. `digits_in` is snapshotted on SHIFT entry.
- SHIFT: en=1. There are 8 bits, MSB first. Each bit sets mosi at bit start with sck=0 for SCK_DIV clks, then sck=1 for SCK_DIV clks. After bit 0, go to DWELL with sck=0.
- DWELL: en=1, sck=0, mosi held, for DWELL clks. On the final DWELL clk, register pressed=~miso.
- LATCH: en=0 for GAP clks. Then t wraps mod 16. If `run`=1, go to SHIFT; otherwise go to IDLE.
- Pipeline alignment: the slave displays and reports the byte latched at the previous LATCH. The sample taken in frame k therefore belongs to step t(k-1). The first frame after reset or after leaving IDLE has no predecessor, so its sample is discarded (prev_valid flag).
- Debounce: a raw 16-bit scan vector is assembled. On completion of the sample for step 15, each bit compares raw against `keys`. A differing bit increments its counter. An equal bit clears its counter. A counter reaching DEB_SCANS flips the `keys` bit and clears the counter. Any flip pulses `key_change` on the same clk the `keys` bit updates.
- `run` deassertion mid-frame lets the current frame complete through LATCH before IDLE.

## Timing
- Reset values: sck=0, mosi=0, en=0, keys=0, key_change=0, state=IDLE, t=0, all debounce counters 0, prev_valid=0.
- Frame period = 16*SCK_DIV + DWELL + GAP clks. en high for 16*SCK_DIV + DWELL, low for GAP.
- Exactly 8 rising sck edges per frame. mosi is stable for SCK_DIV clks before and after each rising edge, except the last bit, which is held through DWELL.
- Full scan = 16 frames. Minimum key latency from stable press = DEB_SCANS full scans plus up to one partial scan plus one frame.
- Reset asserted mid-operation forces all outputs to reset values immediately. The resulting en fall may latch a partial byte in the slave; this is accepted because the next full frame overwrites it.

## Structure
- Package `seg_scan_pkg` holds:
  - the state enum
  - FRAME_BITS=8
  - field positions COL_MSB=7, SCR_MSB=5, DIG_MSB=3
  - the key-index function 4*row+col
- Sub-module `key_debounce`: 16 counters, raw-vector input with scan-done strobe, `keys`/`key_change` outputs.
- The top-level module holds the FSM, SCK divider, shift register and step counter.

## Test plan
- Reset: RESET low mid-SHIFT -> sck=0, mosi=0, en=0, keys=0 on the same clk, no clk edge needed.
- Frame content: SCK_DIV=1, digits_in=16'h4321. Step 0 -> mosi bits at rising sck are 0000_0001 (0x01). Step 5 -> 0x52. Step 15 -> 0xF4.
- Frame timing: SCK_DIV=2, DWELL=10, GAP=2 -> en high 42 clks, low 2 clks, 8 sck rises per frame, period 44.
- Key press: the slave model (the existing decoder) drives miso low while the latched byte has col=2, scr=1 -> keys[6]=1 after DEB_SCANS=3 full scans, with a single key_change pulse. Release -> keys[6]=0 after 3 scans, with one pulse.
- Bounce: key[6] pressed for 2 scans then released, DEB_SCANS=3 -> keys stays 0 and no key_change.
- run control: run drops during bit 3 of SHIFT -> frame completes with 8 sck rises, DWELL and LATCH, then IDLE with en=0. Run re-raised -> first sample discarded and the step continues from t+1.
